// File: rtl/c1541_head_ctrl.sv
// C1541 drive head controller: stepper decode, half-track position, settle timer,
// dirty-track save requests and the disk-change write-protect window.
module c1541_head_ctrl #(
    parameter int CHG_CYCLES    = 15000000,
    parameter int SETTLE_CYCLES = 96000,
    parameter int RESET_HT      = 36,
    parameter int MAX_HT        = 80,
    parameter int MIN_HT        = 1
) (
    input  logic       clk_c1541,
    input  logic       reset,
    input  logic       disk_change,
    input  logic       disk_readonly,
    input  logic       mtr,
    input  logic [1:0] stp,
    input  logic       act,
    input  logic       buff_we,
    input  logic       sd_busy,
    output logic [6:0] half_track,
    output logic [5:0] track,
    output logic       tr00_sense_n,
    output logic       wps_n,
    output logic       save_track,
    output logic       head_settled,
    output logic       save_pend_dbg
);

    localparam int CW = $clog2(CHG_CYCLES + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic {
        IDLE      = 1'b0,
        SAVE_PEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      stp_r_q, stp_r_d;
    logic            act_r_q, act_r_d;
    logic            dc_r_q, dc_r_d;
    logic [6:0]      half_track_q, half_track_d;
    logic [5:0]      track_q, track_d;
    logic            modified_q, modified_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic            readonly_q, readonly_d;
    logic [CW-1:0]   ch_timeout_q, ch_timeout_d;
    logic            ch_state_q, ch_state_d;

    logic step_in, step_out, step_evt, act_fall, save_trig, dc_rise;

    // Quadrature decode of the two-bit stepper phase against last cycle's phase.
    always_comb begin
        step_in  = mtr && (((stp_r_q == 2'd0) && (stp == 2'd2)) ||
                           ((stp_r_q == 2'd2) && (stp == 2'd1)) ||
                           ((stp_r_q == 2'd1) && (stp == 2'd3)) ||
                           ((stp_r_q == 2'd3) && (stp == 2'd0)));
        step_out = mtr && (((stp_r_q == 2'd0) && (stp == 2'd3)) ||
                           ((stp_r_q == 2'd2) && (stp == 2'd0)) ||
                           ((stp_r_q == 2'd1) && (stp == 2'd2)) ||
                           ((stp_r_q == 2'd3) && (stp == 2'd1)));
        step_evt  = step_in || step_out;
        act_fall  = act_r_q && !act;
        save_trig = step_evt || act_fall;
        dc_rise   = disk_change && !dc_r_q;
    end

    always_comb begin
        stp_r_d      = stp;
        act_r_d      = act;
        dc_r_d       = disk_change;
        half_track_d = half_track_q;
        track_d      = half_track_q[6:1];
        settle_d     = settle_q;

        if (step_in && (half_track_q < 7'(MAX_HT))) begin
            half_track_d = half_track_q + 7'd1;
        end else if (step_out && (half_track_q > 7'(MIN_HT))) begin
            half_track_d = half_track_q - 7'd1;
        end

        // A clamped step still restarts the settle timer.
        if (step_evt) begin
            settle_d = SW'(SETTLE_CYCLES - 1);
        end else if (settle_q != '0) begin
            settle_d = settle_q - SW'(1);
        end
    end

    // Save FSM and dirty flag; a trigger while pending folds into that request.
    always_comb begin
        state_d    = state_q;
        save_track = 1'b0;
        modified_d = modified_q;

        case (state_q)
            IDLE: begin
                if (save_trig && modified_q) begin
                    state_d = SAVE_PEND;
                end
            end
            SAVE_PEND: begin
                if (!sd_busy) begin
                    state_d    = IDLE;
                    save_track = !reset;
                end
            end
            default: state_d = IDLE;
        endcase

        if (save_trig && modified_q) begin
            modified_d = 1'b0;
        end
        if (buff_we) begin
            modified_d = 1'b1;
        end
        if (disk_change) begin
            modified_d = 1'b0;
        end
    end

    always_comb begin
        readonly_d   = readonly_q;
        ch_timeout_d = ch_timeout_q;
        ch_state_d   = (ch_timeout_q != '0);
        if (dc_rise) begin
            readonly_d   = disk_readonly;
            ch_timeout_d = CW'(CHG_CYCLES);
        end else if (ch_timeout_q != '0) begin
            ch_timeout_d = ch_timeout_q - CW'(1);
        end
    end

    always_ff @(posedge clk_c1541) begin
        if (reset) begin
            state_q      <= IDLE;
            stp_r_q      <= stp;
            act_r_q      <= act;
            half_track_q <= 7'(RESET_HT);
            track_q      <= 6'(RESET_HT / 2);
            modified_q   <= 1'b0;
            settle_q     <= '0;
        end else begin
            state_q      <= state_d;
            stp_r_q      <= stp_r_d;
            act_r_q      <= act_r_d;
            half_track_q <= half_track_d;
            track_q      <= track_d;
            modified_q   <= modified_d;
            settle_q     <= settle_d;
        end
    end

    // The disk-change window survives a drive reset.
    always_ff @(posedge clk_c1541) begin
        dc_r_q       <= dc_r_d;
        readonly_q   <= readonly_d;
        ch_timeout_q <= ch_timeout_d;
        ch_state_q   <= ch_state_d;
    end

    assign half_track    = half_track_q;
    assign track         = track_q;
    assign tr00_sense_n  = |track_q;
    assign wps_n         = (~readonly_q) ^ ch_state_q;
    assign head_settled  = (settle_q == '0);
    assign save_pend_dbg = (state_q == SAVE_PEND);

endmodule

// File: tb/tb_c1541_head_ctrl.sv
// Bench for c1541_head_ctrl: table-driven step vectors, hand sequences for save,
// settle and disk-change corners, and a queue scoreboard of expected save pulses.
module tb_c1541_head_ctrl;

    localparam int CHG = 100;
    localparam int SETTLE = 20;

    logic       clk_c1541;
    logic       reset;
    logic       disk_change;
    logic       disk_readonly;
    logic       mtr;
    logic [1:0] stp;
    logic       act;
    logic       buff_we;
    logic       sd_busy;
    logic [6:0] half_track;
    logic [5:0] track;
    logic       tr00_sense_n;
    logic       wps_n;
    logic       save_track;
    logic       head_settled;
    logic       save_pend_dbg;

    int n_vec = 0;
    int n_err = 0;
    logic [6:0] exp_q[$];
    logic [6:0] exp_ht;

    c1541_head_ctrl #(
        .CHG_CYCLES(CHG),
        .SETTLE_CYCLES(SETTLE),
        .RESET_HT(36),
        .MAX_HT(80),
        .MIN_HT(1)
    ) dut (
        .clk_c1541(clk_c1541),
        .reset(reset),
        .disk_change(disk_change),
        .disk_readonly(disk_readonly),
        .mtr(mtr),
        .stp(stp),
        .act(act),
        .buff_we(buff_we),
        .sd_busy(sd_busy),
        .half_track(half_track),
        .track(track),
        .tr00_sense_n(tr00_sense_n),
        .wps_n(wps_n),
        .save_track(save_track),
        .head_settled(head_settled),
        .save_pend_dbg(save_pend_dbg)
    );

    // Clock and reset
    initial begin
        clk_c1541 = 1'b0;
        forever #5 clk_c1541 = ~clk_c1541;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk_c1541);
        #1;
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic chg_window(input logic ro, input int reedge, input int reset_at,
                              output int hi_cnt);
        hi_cnt = 0;
        disk_readonly = ro;
        for (int i = 0; i < 300; i++) begin
            disk_change = (i == 0) || (i == reedge);
            reset = (i == reset_at);
            tick();
            if (i >= 1 && wps_n) hi_cnt++;
        end
        disk_change = 1'b0;
        reset = 1'b0;
    endtask

    // Scoreboard: every save_track pulse must match the next expected half_track.
    always @(negedge clk_c1541) begin
        if (save_track === 1'b1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL save_pulse: unexpected save_track at half_track=%0d, expected none",
                         half_track);
            end else begin
                exp_ht = exp_q.pop_front();
                if (half_track !== exp_ht) begin
                    n_err++;
                    $display("FAIL save_pulse_ht: got half_track=%0d, expected %0d",
                             half_track, exp_ht);
                end
            end
        end
    end

    typedef struct {
        logic       mtr;
        logic [1:0] stp;
        logic [6:0] exp_ht;
    } step_vec_t;

    step_vec_t vecs [19];
    logic [1:0] seq_out [4];
    logic [1:0] seq_in [4];
    int prev_ht;
    int low_cnt;
    int hi_cnt;

    initial begin
        vecs = '{
            '{1'b1, 2'd2, 7'd37}, '{1'b1, 2'd1, 7'd38}, '{1'b1, 2'd3, 7'd39},
            '{1'b1, 2'd0, 7'd40}, '{1'b1, 2'd0, 7'd40}, '{1'b1, 2'd1, 7'd40},
            '{1'b1, 2'd0, 7'd40}, '{1'b1, 2'd3, 7'd39}, '{1'b1, 2'd1, 7'd38},
            '{1'b1, 2'd2, 7'd37}, '{1'b1, 2'd0, 7'd36}, '{1'b1, 2'd2, 7'd37},
            '{1'b1, 2'd3, 7'd37}, '{1'b1, 2'd2, 7'd37}, '{1'b1, 2'd0, 7'd36},
            '{1'b0, 2'd2, 7'd36}, '{1'b0, 2'd1, 7'd36}, '{1'b0, 2'd3, 7'd36},
            '{1'b0, 2'd0, 7'd36}
        };
        seq_out = '{2'd3, 2'd1, 2'd2, 2'd0};
        seq_in  = '{2'd2, 2'd1, 2'd3, 2'd0};

        reset = 1'b1;
        disk_change = 1'b0;
        disk_readonly = 1'b0;
        mtr = 1'b0;
        stp = 2'd0;
        act = 1'b0;
        buff_we = 1'b0;
        sd_busy = 1'b0;
        repeat (3) tick();
        chk("reset_half_track", half_track, 36);
        chk("reset_settled", head_settled, 1);
        chk("reset_save_track", save_track, 0);
        reset = 1'b0;
        tick();
        chk("post_reset_track", track, 18);
        chk("post_reset_tr00", tr00_sense_n, 1);

        // Step decode table, including mtr=0 rows that must not move the head.
        prev_ht = 36;
        for (int v = 0; v < 19; v++) begin
            mtr = vecs[v].mtr;
            stp = vecs[v].stp;
            tick();
            chk($sformatf("vec%0d_half_track", v), half_track, vecs[v].exp_ht);
            chk($sformatf("vec%0d_track", v), track, prev_ht / 2);
            prev_ht = vecs[v].exp_ht;
        end

        // Four steps in, then settle timer measurement.
        repeat (25) tick();
        mtr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stp = seq_in[i];
            tick();
        end
        chk("step_in_40", half_track, 40);
        low_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (!head_settled) low_cnt++;
            tick();
        end
        // Plus the cycle in which stp changed, this spans SETTLE cycles.
        chk("settle_low_cycles", low_cnt, SETTLE - 1);
        chk("track_20", track, 20);

        // Walk out to half-track 1, then a clamped step out.
        for (int i = 0; i < 39; i++) begin
            stp = seq_out[i % 4];
            tick();
        end
        chk("walk_out_ht1", half_track, 1);
        repeat (25) tick();
        chk("settled_before_clamp", head_settled, 1);
        stp = 2'd0;
        tick();
        chk("clamp_min_ht", half_track, 1);
        chk("clamp_min_settle_restart", head_settled, 0);
        tick();
        chk("clamp_min_track", track, 0);
        chk("clamp_min_tr00", tr00_sense_n, 0);

        // Walk in past the upper limit.
        for (int i = 0; i < 80; i++) begin
            stp = seq_in[i % 4];
            tick();
        end
        chk("clamp_max_ht", half_track, 80);
        tick();
        chk("clamp_max_track", track, 40);
        chk("clamp_max_tr00", tr00_sense_n, 1);

        // Save held off by sd_busy, released on the first idle cycle.
        buff_we = 1'b1;
        tick();
        buff_we = 1'b0;
        sd_busy = 1'b1;
        stp = 2'd3;
        exp_q.push_back(7'd79);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("busy_no_pulse%0d", i), save_track, 0);
            tick();
        end
        sd_busy = 1'b0;
        #1;
        chk("busy_release_pulse", save_track, 1);
        tick();
        chk("busy_release_single", save_track, 0);

        // act falling then a step while pending merge into one pulse.
        buff_we = 1'b1;
        tick();
        buff_we = 1'b0;
        sd_busy = 1'b1;
        act = 1'b1;
        tick();
        act = 1'b0;
        exp_q.push_back(7'd78);
        tick();
        stp = 2'd1;
        tick();
        chk("merge_step_ht", half_track, 78);
        repeat (5) tick();
        sd_busy = 1'b0;
        repeat (10) tick();

        // buff_we coincident with a trigger keeps the track dirty.
        buff_we = 1'b1;
        tick();
        sd_busy = 1'b1;
        stp = 2'd2;
        exp_q.push_back(7'd77);
        tick();
        buff_we = 1'b0;
        sd_busy = 1'b0;
        tick();
        act = 1'b1;
        tick();
        act = 1'b0;
        exp_q.push_back(7'd77);
        tick();
        repeat (5) tick();

        // Reset while a save is pending drops it.
        buff_we = 1'b1;
        tick();
        buff_we = 1'b0;
        sd_busy = 1'b1;
        stp = 2'd0;
        tick();
        reset = 1'b1;
        sd_busy = 1'b0;
        #1;
        chk("reset_gates_save", save_track, 0);
        tick();
        chk("reset_mid_ht", half_track, 36);
        chk("reset_mid_settled", head_settled, 1);
        reset = 1'b0;
        tick();
        chk("reset_mid_track", track, 18);
        repeat (5) tick();

        // disk_change clears the dirty flag; writable image window.
        buff_we = 1'b1;
        tick();
        buff_we = 1'b0;
        chg_window(1'b0, -1, -1, hi_cnt);
        chk("rw_window_low_cycles", 299 - hi_cnt, CHG);
        chk("rw_after_window", wps_n, 1);
        act = 1'b1;
        tick();
        act = 1'b0;
        repeat (5) tick();

        // Read-only image window, then a re-edge at cycle 50 with a reset inside.
        chg_window(1'b1, -1, -1, hi_cnt);
        chk("ro_window_high_cycles", hi_cnt, CHG);
        chk("ro_after_window", wps_n, 0);
        chg_window(1'b1, 50, 20, hi_cnt);
        chk("ro_reedge_high_cycles", hi_cnt, CHG + 50);
        chk("ro_reedge_after", wps_n, 0);

        repeat (5) tick();
        chk("save_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
